// File: rtl/gf_exp_ctrl_if.sv
// Host-side request/response bundle for gf_exp_ctrl.
//   start    : request strobe, taken only while the sequencer is idle
//   base     : field element (latched on accept)
//   exponent : exponent (latched on accept)
//   poly     : reduction polynomial, low coefficients only (latched on accept)
//   busy     : sequencer is not idle
//   done     : one-cycle pulse, result valid
//   result   : base^exponent mod poly, held until the next done
// master = host side, slave = sequencer side.
interface gf_exp_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] base;
  logic [EXP_WIDTH-1:0]  exponent;
  logic [DATA_WIDTH-1:0] poly;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, base, exponent, poly,
    input  busy, done, result
  );

  modport slave (
    input  start, base, exponent, poly,
    output busy, done, result
  );
endinterface

// File: rtl/gf_exp_ctrl.sv
// GF(2^DATA_WIDTH) exponentiation sequencer (left-to-right square-and-multiply).
// Drives an external combinational carry-less multiplier in multiply mode and
// reduces each 2W-bit product one coefficient per cycle.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   host             : request/response bundle (gf_exp_ctrl_if.slave)
//   u_sum_funct      : datapath mode select, tied 0 (multiply)
//   u_exp_funct      : datapath mode select, tied 0
//   u_carry_option   : datapath carry select, tied 0 (carry-less)
//   u_a, u_b         : datapath operands, registered; 0 outside SQR/MUL
//   u_mult_out       : 2W-bit carry-less product from the datapath
//
// state | meaning
// IDLE  | waiting for start
// SQR   | u_a=u_b=acc, capture product
// RED_S | reduce squared product, one coefficient per cycle
// MUL   | u_a=acc, u_b=base, capture product
// RED_M | reduce multiplied product, one coefficient per cycle
// DONE  | done pulse, result valid
module gf_exp_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gf_exp_ctrl_if.slave            host,
  output logic                    u_sum_funct,
  output logic                    u_exp_funct,
  output logic                    u_carry_option,
  output logic [DATA_WIDTH-1:0]   u_a,
  output logic [DATA_WIDTH-1:0]   u_b,
  input  logic [2*DATA_WIDTH-1:0] u_mult_out
);

  localparam int J_W = $clog2(2 * DATA_WIDTH);
  localparam int I_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  localparam logic [J_W-1:0]        J_TOP = J_W'(2 * DATA_WIDTH - 2);
  localparam logic [J_W-1:0]        J_LOW = J_W'(DATA_WIDTH);
  localparam logic [I_W-1:0]        I_TOP = I_W'(EXP_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQR   = 3'd1,
    RED_S = 3'd2,
    MUL   = 3'd3,
    RED_M = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   acc;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [I_W-1:0]          i;
  logic [J_W-1:0]          j;
  logic [DATA_WIDTH-1:0]   base_r;
  logic [EXP_WIDTH-1:0]    exp_r;
  logic [DATA_WIDTH-1:0]   poly_r;

  logic                    busy_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   result_q;

  logic [2*DATA_WIDTH-1:0] poly_full;
  logic [2*DATA_WIDTH-1:0] red_prod;
  logic [DATA_WIDTH-1:0]   red_lo;

  assign u_sum_funct    = 1'b0;
  assign u_exp_funct    = 1'b0;
  assign u_carry_option = 1'b0;

  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.result = result_q;

  // One reduction step: cancel coefficient j with x^(j-W) * (x^W + poly).
  always_comb begin
    poly_full                 = '0;
    poly_full[DATA_WIDTH:0]   = {1'b1, poly_r};
    red_prod                  = prod;
    if (prod[j]) begin
      red_prod = prod ^ (poly_full << (j - J_LOW));
    end
    red_lo = red_prod[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      u_a      <= '0;
      u_b      <= '0;
      acc      <= '0;
      prod     <= '0;
      i        <= '0;
      j        <= '0;
      base_r   <= '0;
      exp_r    <= '0;
      poly_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (host.start) begin
            base_r <= host.base;
            exp_r  <= host.exponent;
            poly_r <= host.poly;
            acc    <= ONE;
            i      <= I_TOP;
            // operands are registered, so load them for the coming SQR now
            u_a    <= ONE;
            u_b    <= ONE;
            busy_q <= 1'b1;
            state  <= SQR;
          end
        end

        SQR, MUL: begin
          prod  <= u_mult_out;
          j     <= J_TOP;
          u_a   <= '0;
          u_b   <= '0;
          state <= (state == SQR) ? RED_S : RED_M;
        end

        RED_S, RED_M: begin
          prod <= red_prod;
          if (j == J_LOW) begin
            acc <= red_lo;
            if (state == RED_S && exp_r[i]) begin
              u_a   <= red_lo;
              u_b   <= base_r;
              state <= MUL;
            end else if (i == '0) begin
              // result and done are presented together for the DONE cycle
              result_q <= red_lo;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              i     <= i - 1'b1;
              u_a   <= red_lo;
              u_b   <= red_lo;
              state <= SQR;
            end
          end else begin
            j <= j - 1'b1;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          u_a    <= '0;
          u_b    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_exp_ctrl.sv
module tb_gf_exp_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- W=4 / E=4 instance ----------------
  gf_exp_ctrl_if #(.DATA_WIDTH(4), .EXP_WIDTH(4)) if4 ();
  logic       sf4, ef4, cf4;
  logic [3:0] ua4, ub4;
  logic [7:0] um4;
  logic [15:0] m4_full;

  gf_exp_ctrl #(.DATA_WIDTH(4), .EXP_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .host(if4),
    .u_sum_funct(sf4), .u_exp_funct(ef4), .u_carry_option(cf4),
    .u_a(ua4), .u_b(ub4), .u_mult_out(um4)
  );

  // ---------------- W=8 / E=8 instance ----------------
  gf_exp_ctrl_if #(.DATA_WIDTH(8), .EXP_WIDTH(8)) if8 ();
  logic        sf8, ef8, cf8;
  logic [7:0]  ua8, ub8;
  logic [15:0] um8;

  gf_exp_ctrl #(.DATA_WIDTH(8), .EXP_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .host(if8),
    .u_sum_funct(sf8), .u_exp_funct(ef8), .u_carry_option(cf8),
    .u_a(ua8), .u_b(ub8), .u_mult_out(um8)
  );

  // External combinational carry-less multiplier.
  function automatic logic [15:0] clmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (b[k]) r = r ^ (16'(a) << k);
    return r;
  endfunction

  assign m4_full = clmul({4'd0, ua4}, {4'd0, ub4});
  assign um4     = m4_full[7:0];
  assign um8     = clmul(ua8, ub8);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] res;
    int         lat;
    int         acc_cyc;
    string      name;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Latency is counted in clock edges from the accept edge to the first edge
  // that samples done high (the monitor runs half a cycle before that edge).
  always @(negedge clk) begin
    if (rst_n && if4.done) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk({e.name, "_result"}, 32'(if4.result), 32'(e.res));
        chk({e.name, "_latency"}, 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        chk({e.name, "_busy_at_done"}, 32'(if4.busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if8.done) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk({e.name, "_result"}, 32'(if8.result), 32'(e.res));
        chk({e.name, "_latency"}, 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue4(input logic [3:0] b, input logic [3:0] e,
                        input logic [3:0] res, input string name);
    exp_t x;
    @(negedge clk);
    if4.start    = 1'b1;
    if4.base     = b;
    if4.exponent = e;
    if4.poly     = 4'b0011;
    x.res     = {4'd0, res};
    x.lat     = (4 + $countones(e)) * 4 + 1;
    x.acc_cyc = cyc + 1;
    x.name    = name;
    q4.push_back(x);
    @(negedge clk);
    // scramble live inputs; only the latched copies may be used
    if4.start    = 1'b0;
    if4.base     = 4'($urandom);
    if4.exponent = 4'($urandom);
    if4.poly     = 4'($urandom);
  endtask

  task automatic wait4(input string name);
    for (int k = 0; k < 200 && q4.size() != 0; k++) @(negedge clk);
    if (q4.size() != 0) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
      q4.delete();
    end
    @(negedge clk);
  endtask

  task automatic run4(input logic [3:0] b, input logic [3:0] e,
                      input logic [3:0] res, input string name);
    issue4(b, e, res, name);
    wait4(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n        = 1'b0;
    if4.start    = 1'b0;
    if4.base     = '0;
    if4.exponent = '0;
    if4.poly     = 4'b0011;
    if8.start    = 1'b0;
    if8.base     = '0;
    if8.exponent = '0;
    if8.poly     = 8'h1B;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_done", 32'(if4.done), 32'd0);
    chk("rst_result", 32'(if4.result), 32'd0);
    chk("rst_u_a", 32'(ua4), 32'd0);
    chk("rst_u_b", 32'(ub4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run4(4'd2, 4'd4,  4'd3, "x_pow4");
    run4(4'd2, 4'd15, 4'd1, "x_pow15");
    run4(4'd3, 4'd2,  4'd5, "b3_pow2");
    run4(4'd0, 4'd0,  4'd1, "zero_pow0");
    run4(4'd0, 4'd5,  4'd0, "zero_pow5");
    run4(4'd3, 4'd15, 4'd1, "b3_pow15");
    run4(4'd7, 4'd1,  4'd7, "b7_pow1");
    chk("idle_busy", 32'(if4.busy), 32'd0);
    chk("idle_u_a", 32'(ua4), 32'd0);

    // start while busy must be ignored
    issue4(4'd2, 4'd4, 4'd3, "start_while_busy");
    repeat (5) @(negedge clk);
    if4.start    = 1'b1;
    if4.base     = 4'd3;
    if4.exponent = 4'd2;
    @(negedge clk);
    if4.start = 1'b0;
    chk("busy_after_ignored_start", 32'(if4.busy), 32'd1);
    wait4("start_while_busy");

    // start presented during the DONE cycle must be ignored
    issue4(4'd2, 4'd1, 4'd2, "start_in_done");
    begin
      int k;
      for (k = 0; k < 100 && !if4.done; k++) @(negedge clk);
      if (!if4.done) chk("start_in_done_timeout", 32'd1, 32'd0);
    end
    if4.start    = 1'b1;
    if4.base     = 4'd3;
    if4.exponent = 4'd2;
    @(negedge clk);
    if4.start = 1'b0;
    chk("start_in_done_busy", 32'(if4.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("start_in_done_still_idle", 32'(if4.busy), 32'd0);
    q4.delete();

    // reset while in RED_M (accept edge a; RED_M spans edges a+9..a+11)
    issue4(4'd2, 4'd4, 4'd3, "reset_mid");
    repeat (9) @(negedge clk);
    chk("busy_before_reset", 32'(if4.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    q4.delete();
    chk("mid_rst_busy", 32'(if4.busy), 32'd0);
    chk("mid_rst_done", 32'(if4.done), 32'd0);
    chk("mid_rst_result", 32'(if4.result), 32'd0);
    chk("mid_rst_u_a", 32'(ua4), 32'd0);
    chk("mid_rst_u_b", 32'(ub4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run4(4'd2, 4'd4, 4'd3, "after_reset");

    // W=8 AES field inverse
    begin
      exp_t x;
      @(negedge clk);
      if8.start    = 1'b1;
      if8.base     = 8'h53;
      if8.exponent = 8'hFE;
      x.res     = 8'hCA;
      x.lat     = (8 + 7) * 8 + 1;
      x.acc_cyc = cyc + 1;
      x.name    = "aes_inv53";
      q8.push_back(x);
      @(negedge clk);
      if8.start    = 1'b0;
      if8.base     = 8'hFF;
      if8.exponent = 8'h00;
      if8.poly     = 8'h00;
      chk("w8_sum_funct", 32'(sf8), 32'd0);
      chk("w8_exp_funct", 32'(ef8), 32'd0);
      chk("w8_carry_option", 32'(cf8), 32'd0);
      for (int k = 0; k < 400 && q8.size() != 0; k++) @(negedge clk);
      if (q8.size() != 0) begin
        chk("aes_inv53_timeout", 32'd1, 32'd0);
        q8.delete();
      end
      @(negedge clk);
      chk("w8_idle_u_a", 32'(ua8), 32'd0);
      chk("w8_idle_u_b", 32'(ub8), 32'd0);
      chk("w4_tied", 32'({sf4, ef4, cf4}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
